// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared NOP encodings, stage payload widths and skid state encoding
package pipe_stage_skid_pkg;

    localparam logic [3:0] EX_NOP     = 4'd0;
    localparam logic [2:0] EX_RES_NOP = 3'd0;

    // Packed payload width at each stage boundary; packing is done by the instantiating stage.
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 32;
    localparam int EX_MEM_W = 48;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// rtl/pipe_stage_skid_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with 2-entry skid buffer, flush and bubble counter
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W    = ID_EX_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              main_valid;
    logic              skid_valid;
    logic              push;
    logic              pop;

    // Valid bits and occupancy are decoded straight from the state flops, so in_ready never sees out_ready.
    assign main_valid = (state != ST_EMPTY);
    assign skid_valid = (state == ST_FULL);
    assign occupancy  = state;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : NOP_VALUE;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_data <= NOP_VALUE;
            skid_data <= NOP_VALUE;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state     <= ST_ONE;
                        main_data <= in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_data <= in_data;
                    end else if (push) begin
                        state     <= ST_FULL;
                        skid_data <= in_data;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state     <= ST_ONE;
                        main_data <= skid_data;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk(clk),
        .clr(rst),
        .inc(out_ready && !out_valid),
        .cnt(bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed vector table plus queue-model soak for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] bubble_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          eov;
        logic [DW-1:0] eod;
        logic          eir;
        logic [1:0]    eocc;
        logic [CW-1:0] ebub;
    } vec_t;

    vec_t vt[$];

    pipe_stage_skid #(
        .DATA_W(DW),
        .NOP_VALUE('0),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                       input logic o, input logic eov, input logic [DW-1:0] eod,
                       input logic eir, input logic [1:0] eocc, input logic [CW-1:0] ebub);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = o;
        v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc; v.ebub = ebub;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic eov, input logic [DW-1:0] eod,
                       input logic eir, input logic [1:0] eocc, input logic [CW-1:0] ebub);
        n_vec++;
        if (out_valid !== eov || out_data !== eod || in_ready !== eir ||
            occupancy !== eocc || bubble_cnt !== ebub ||
            (dut.skid_valid && !dut.main_valid)) begin
            n_fail++;
            $display("FAIL %s: got ov=%0b od=%h ir=%0b occ=%0d bub=%0d inv=%0b, want ov=%0b od=%h ir=%0b occ=%0d bub=%0d inv=1",
                     nm, out_valid, out_data, in_ready, occupancy, bubble_cnt,
                     !(dut.skid_valid && !dut.main_valid), eov, eod, eir, eocc, ebub);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [DW-1:0] d, input logic o);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
    endtask

    logic [DW-1:0] q[$];
    logic [CW-1:0] mb;

    initial begin
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // reset held two cycles with junk input
        add(1,0,1,32'hDEAD_BEEF,0, 0,32'h0,1,0,0);
        add(1,0,1,32'hDEAD_BEEF,0, 0,32'h0,1,0,0);
        // streaming with out_ready high
        add(0,0,1,32'h1,1, 1,32'h1,1,1,1);
        add(0,0,1,32'h2,1, 1,32'h2,1,1,1);
        add(0,0,1,32'h3,1, 1,32'h3,1,1,1);
        add(0,0,1,32'h4,1, 1,32'h4,1,1,1);
        add(0,0,0,32'h0,1, 0,32'h0,1,0,1);
        // backpressure: A, B fill, C refused, then drain A B C
        add(0,0,1,32'hA,0, 1,32'hA,1,1,1);
        add(0,0,1,32'hB,0, 1,32'hA,0,2,1);
        add(0,0,1,32'hC,0, 1,32'hA,0,2,1);
        add(0,0,1,32'hC,1, 1,32'hB,1,1,1);
        add(0,0,1,32'hC,1, 1,32'hC,1,1,1);
        add(0,0,0,32'h0,1, 0,32'h0,1,0,1);
        // flush from FULL with F presented
        add(0,0,1,32'hA,0, 1,32'hA,1,1,1);
        add(0,0,1,32'hB,0, 1,32'hA,0,2,1);
        add(0,1,1,32'hF,0, 0,32'h0,1,0,1);
        add(0,0,0,32'h0,0, 0,32'h0,1,0,1);
        // flush coinciding with a pop
        add(0,0,1,32'h5,0, 1,32'h5,1,1,1);
        add(0,1,1,32'h6,1, 0,32'h0,1,0,1);
        // bubble counter saturation at 15
        for (int i = 0; i < 20; i++)
            add(0,0,0,32'h0,1, 0,32'h0,1,0,((2 + i) > 15) ? 4'd15 : 4'(2 + i));
        add(1,0,0,32'h0,1, 0,32'h0,1,0,0);
        // reset mid-operation drops held entries
        add(0,0,1,32'h7,0, 1,32'h7,1,1,0);
        add(0,0,1,32'h8,0, 1,32'h7,0,2,0);
        add(1,0,1,32'h9,1, 0,32'h0,1,0,0);
        add(0,0,0,32'h0,0, 0,32'h0,1,0,0);

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].d, vt[i].ordy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vt[i].eov, vt[i].eod, vt[i].eir, vt[i].eocc, vt[i].ebub);
        end

        // random soak against a reference queue; first cycle forces reset to sync the model
        mb = '0;
        for (int c = 0; c < 10000; c++) begin
            logic r, f, iv, o, m_push, m_pop, b_inc;
            logic [DW-1:0] d;
            logic eir;
            r  = (c == 0) || ($urandom_range(0, 499) == 0);
            f  = ($urandom_range(0, 29) == 0);
            iv = ($urandom_range(0, 99) < 60);
            o  = ($urandom_range(0, 99) < 55);
            d  = $urandom;
            eir    = (q.size() < 2);
            m_push = iv && eir;
            m_pop  = (q.size() > 0) && o;
            b_inc  = o && (q.size() == 0);

            // in_ready must not move when out_ready flips within the cycle
            drive(r, f, iv, d, !o);
            #1;
            if (c > 0) begin
                n_vec++;
                if (in_ready !== eir) begin
                    n_fail++;
                    $display("FAIL comb_ready c%0d: got ir=%0b want ir=%0b", c, in_ready, eir);
                end
            end
            out_ready = o;
            @(posedge clk);

            if (r) begin
                q.delete();
                mb = '0;
            end else begin
                if (f) begin
                    q.delete();
                end else begin
                    if (m_pop) void'(q.pop_front());
                    if (m_push) q.push_back(d);
                end
                if (b_inc && mb != 4'd15) mb = mb + 1'b1;
            end
            #1;
            chk($sformatf("soak%0d", c), q.size() > 0, (q.size() > 0) ? q[0] : 32'h0,
                q.size() < 2, 2'(q.size()), mb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
